// File: rtl/mem_io_responder_if.sv
// CPU byte-bus bundle between the memory controller and the responder.
// master = CPU side, slave = memory/IO side.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_dout,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// 128 KB byte RAM plus UART/counter/stop IO window at a[17:16]==2'b11.
// Optional RX FIFO and 0x30000 read-pop path: define MEM_IO_RX_EN.
module mem_io_responder #(
  parameter int          RAM_ADDR_W   = 17,
  parameter int          TX_DEPTH_LOG = 3,
  parameter int          FULL_MARGIN  = 2,
  parameter int          RX_DEPTH_LOG = 2,
  // counter value loaded on reset; 0 in normal builds
  parameter logic [31:0] CNT_INIT     = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              prog_stop,
  output logic              halted,
  output logic              tx_overflow
);

  localparam int TXW = TX_DEPTH_LOG + 1;
  localparam int TX_N = 1 << TX_DEPTH_LOG;
  localparam logic [TXW-1:0] TX_NV =
    TX_N[TXW-1:0];
  localparam logic [TXW-1:0] MARGIN =
    FULL_MARGIN[TXW-1:0];

  logic [17:0]           a_lo;
  logic                  io, rd, wr;
  logic [RAM_ADDR_W-1:0] idx;
  logic sel_data, sel_cnt;
  logic sel_s1, sel_s2, sel_s3;
  logic unused_hi;

  assign a_lo = bus.mem_a[17:0];
  assign io = (a_lo[17:16] == 2'b11);
  assign idx = bus.mem_a[RAM_ADDR_W-1:0];
  assign wr = bus.mem_wr;
  assign rd = !bus.mem_wr;
  assign unused_hi = ^bus.mem_a[31:18];

  assign sel_data = io && (a_lo[15:0] == 16'h0000);
  assign sel_cnt  = io && (a_lo[15:0] == 16'h0004);
  assign sel_s1   = io && (a_lo[15:0] == 16'h0005);
  assign sel_s2   = io && (a_lo[15:0] == 16'h0006);
  assign sel_s3   = io && (a_lo[15:0] == 16'h0007);

  logic [7:0] ram [2**RAM_ADDR_W];

  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (wr && !io) ram[idx] <= bus.mem_dout;
  end

  logic [31:0] cnt, snap;

  // free-running cycle counter and 0x30004 snapshot
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt  <= CNT_INIT;
      snap <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (rd && sel_cnt) snap <= cnt;
    end
  end

  logic [7:0] rx_head;
  logic       rx_nonempty;

`ifdef MEM_IO_RX_EN
  localparam int RXW = RX_DEPTH_LOG + 1;
  localparam int RX_N = 1 << RX_DEPTH_LOG;
  localparam logic [RXW-1:0] RX_NV =
    RX_N[RXW-1:0];

  logic [7:0]              rx_mem [RX_N];
  logic [RX_DEPTH_LOG-1:0] rx_wp, rx_rp;
  logic [RXW-1:0]          rx_cnt;
  logic                    rx_pop, rx_push;

  assign rx_nonempty = (rx_cnt != '0);
  assign rx_head = rx_mem[rx_rp];
  assign rx_pop = rd && sel_data && rx_nonempty;
  // a read pop frees the slot this byte lands in
  assign rx_push = rx_valid &&
    ((rx_cnt != RX_NV) || rx_pop);

  // RX storage
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push)
        rx_wp <= rx_wp + RX_DEPTH_LOG'(1);
      if (rx_pop)
        rx_rp <= rx_rp + RX_DEPTH_LOG'(1);
      if (rx_push && !rx_pop)
        rx_cnt <= rx_cnt + RXW'(1);
      else if (rx_pop && !rx_push)
        rx_cnt <= rx_cnt - RXW'(1);
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid};
  assign rx_head = 8'h00;
  assign rx_nonempty = 1'b0;
`endif

  logic [7:0] io_rdata;

  // IO read data mux
  always_comb begin
    io_rdata = 8'h00;
    unique case (1'b1)
      sel_data: io_rdata = rx_nonempty ? rx_head : 8'h00;
      sel_cnt:  io_rdata = cnt[7:0];
      sel_s1:   io_rdata = snap[15:8];
      sel_s2:   io_rdata = snap[23:16];
      sel_s3:   io_rdata = snap[31:24];
      default:  io_rdata = 8'h00;
    endcase
  end

  // read data register; held across write cycles
  always_ff @(posedge clk_in) begin
    if (rst_in) bus.mem_din <= 8'h00;
    else if (rd) bus.mem_din <= io ? io_rdata : ram[idx];
  end

  logic [7:0]              tx_mem [TX_N];
  logic [TX_DEPTH_LOG-1:0] tx_wp, tx_rp;
  logic [TXW-1:0]          tx_cnt, tx_cnt_nxt, tx_free_nxt;
  logic                    tx_req, tx_full, tx_pop, tx_push;
  logic [7:0]              tx_byte;

  assign tx_req = wr &&
    ((sel_data && (bus.mem_dout != 8'h00)) || sel_cnt);
  assign tx_byte = sel_cnt ? 8'h00 : bus.mem_dout;
  assign tx_full = (tx_cnt == TX_NV);
  assign tx_valid = (tx_cnt != '0);
  assign tx_data = tx_mem[tx_rp];
  assign tx_pop = tx_valid && tx_ready;
  assign tx_push = tx_req && (!tx_full || tx_pop);

  // TX occupancy after this edge, feeds back-pressure
  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_push && !tx_pop)
      tx_cnt_nxt = tx_cnt + TXW'(1);
    else if (tx_pop && !tx_push)
      tx_cnt_nxt = tx_cnt - TXW'(1);
    tx_free_nxt = TX_NV - tx_cnt_nxt;
  end

  // TX storage
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp] <= tx_byte;
  end

  // TX pointers, near-full flag and drop flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wp              <= '0;
      tx_rp              <= '0;
      tx_cnt             <= '0;
      bus.io_buffer_full <= 1'b0;
      tx_overflow        <= 1'b0;
    end else begin
      if (tx_push)
        tx_wp <= tx_wp + TX_DEPTH_LOG'(1);
      if (tx_pop)
        tx_rp <= tx_rp + TX_DEPTH_LOG'(1);
      tx_cnt <= tx_cnt_nxt;
      bus.io_buffer_full <= (tx_free_nxt <= MARGIN);
      if (tx_req && tx_full && !tx_pop)
        tx_overflow <= 1'b1;
    end
  end

  // program-stop pulse and sticky halt
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prog_stop <= 1'b0;
      halted    <= 1'b0;
    end else begin
      prog_stop <= wr && sel_cnt;
      if (wr && sel_cnt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder.
// Inputs change after negedge; outputs checked at the following negedge.
module tb_mem_io_responder;

  localparam logic [31:0] INIT = 32'hFFFF_FFF0;
  localparam logic [31:0] IDLE = 32'h0000_0010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       prog_stop, halted, tx_overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_cnt;
  logic [7:0]  txq [$];

  mem_io_responder_if bus_if ();

  mem_io_responder #(.CNT_INIT(INIT)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .bus         (bus_if),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .prog_stop   (prog_stop),
    .halted      (halted),
    .tx_overflow (tx_overflow)
  );

  always #5 clk = ~clk;

  // expected counter: INIT at reset, +1 per cycle
  always @(posedge clk) begin
    if (rst) tb_cnt <= INIT;
    else tb_cnt <= tb_cnt + 32'd1;
  end

  // collect every byte the UART side accepts
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic [31:0] a,
                     input logic w,
                     input logic [7:0] d);
    bus_if.mem_a = a;
    bus_if.mem_wr = w;
    bus_if.mem_dout = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(IDLE, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks += 6;
    if (bus_if.mem_din !== 8'h00) begin
      $display("FAIL rst_din: got %h expected 00", bus_if.mem_din);
      errors++;
    end
    if (tx_valid !== 1'b0) begin
      $display("FAIL rst_txv: got %b expected 0", tx_valid);
      errors++;
    end
    if (bus_if.io_buffer_full !== 1'b0) begin
      $display("FAIL rst_ibf: got %b expected 0",
               bus_if.io_buffer_full);
      errors++;
    end
    if (prog_stop !== 1'b0) begin
      $display("FAIL rst_stop: got %b expected 0", prog_stop);
      errors++;
    end
    if (halted !== 1'b0) begin
      $display("FAIL rst_halt: got %b expected 0", halted);
      errors++;
    end
    if (tx_overflow !== 1'b0) begin
      $display("FAIL rst_ovf: got %b expected 0", tx_overflow);
      errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_ram;
    bus(32'h0_0010, 1'b1, 8'h5A);
    bus(32'h0_0010, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'h5A) begin
      $display("FAIL ram_10: got %h expected 5a", bus_if.mem_din);
      errors++;
    end
    bus(32'h1_FFFF, 1'b1, 8'hC3);
    checks++;
    if (bus_if.mem_din !== 8'h5A) begin
      $display("FAIL ram_hold: got %h expected 5a", bus_if.mem_din);
      errors++;
    end
    bus(32'h1_FFFF, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'hC3) begin
      $display("FAIL ram_top: got %h expected c3", bus_if.mem_din);
      errors++;
    end
  endtask

  task automatic test_tx;
    tx_ready = 1'b1;
    txq.delete();
    bus(32'h3_0000, 1'b1, 8'h41);
    bus(32'h3_0000, 1'b1, 8'h00);
    bus(32'h3_0000, 1'b1, 8'h42);
    idle(4);
    checks += 4;
    if (txq.size() !== 2) begin
      $display("FAIL tx_len: got %0d expected 2", txq.size());
      errors++;
    end else if (txq[0] !== 8'h41 || txq[1] !== 8'h42) begin
      $display("FAIL tx_seq: got %h %h expected 41 42",
               txq[0], txq[1]);
      errors++;
    end
    if (tx_overflow !== 1'b0) begin
      $display("FAIL tx_ovf: got %b expected 0", tx_overflow);
      errors++;
    end
    if (tx_valid !== 1'b0) begin
      $display("FAIL tx_empty: got %b expected 0", tx_valid);
      errors++;
    end
    if (bus_if.io_buffer_full !== 1'b0) begin
      $display("FAIL tx_ibf: got %b expected 0",
               bus_if.io_buffer_full);
      errors++;
    end
  endtask

  task automatic test_back_pressure;
    tx_ready = 1'b0;
    txq.delete();
    for (int i = 0; i < 9; i++) begin
      bus(32'h3_0000, 1'b1, 8'h11 + 8'(i));
      if (i == 4 || i == 5) begin
        checks++;
        if (bus_if.io_buffer_full !== (i == 5)) begin
          $display("FAIL bp_ibf%0d: got %b expected %b", i + 1,
                   bus_if.io_buffer_full, i == 5);
          errors++;
        end
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (tx_overflow !== (i == 8)) begin
          $display("FAIL bp_ovf%0d: got %b expected %b", i + 1,
                   tx_overflow, i == 8);
          errors++;
        end
      end
    end
    tx_ready = 1'b1;
    idle(12);
    checks++;
    if (txq.size() !== 8) begin
      $display("FAIL bp_len: got %0d expected 8", txq.size());
      errors++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (txq[i] !== 8'h11 + 8'(i)) begin
          $display("FAIL bp_byte%0d: got %h expected %h", i,
                   txq[i], 8'h11 + 8'(i));
          errors++;
        end
      end
    end
    checks++;
    if (bus_if.io_buffer_full !== 1'b0) begin
      $display("FAIL bp_ibf_end: got %b expected 0",
               bus_if.io_buffer_full);
      errors++;
    end
  endtask

  task automatic test_counter;
    logic [31:0] exp;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    exp = tb_cnt;
    bus(32'h3_0004, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== exp[7:0]) begin
      $display("FAIL cnt_b0: got %h expected %h",
               bus_if.mem_din, exp[7:0]);
      errors++;
    end
    bus(32'h3_0005, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== exp[15:8]) begin
      $display("FAIL cnt_b1: got %h expected %h",
               bus_if.mem_din, exp[15:8]);
      errors++;
    end
    bus(32'h3_0006, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== exp[23:16]) begin
      $display("FAIL cnt_b2: got %h expected %h",
               bus_if.mem_din, exp[23:16]);
      errors++;
    end
    bus(32'h3_0007, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== exp[31:24]) begin
      $display("FAIL cnt_b3: got %h expected %h",
               bus_if.mem_din, exp[31:24]);
      errors++;
    end
    for (int i = 0; i < 64 && tb_cnt !== 32'hFFFF_FFFF; i++)
      idle(1);
    checks++;
    if (tb_cnt !== 32'hFFFF_FFFF) begin
      $display("FAIL cnt_reach: got %h expected ffffffff", tb_cnt);
      errors++;
    end
    bus(32'h3_0004, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'hFF) begin
      $display("FAIL cnt_max: got %h expected ff", bus_if.mem_din);
      errors++;
    end
    bus(32'h3_0004, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'h00) begin
      $display("FAIL cnt_wrap: got %h expected 00", bus_if.mem_din);
      errors++;
    end
    bus(32'h3_0007, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'h00) begin
      $display("FAIL cnt_wrap_hi: got %h expected 00",
               bus_if.mem_din);
      errors++;
    end
  endtask

  task automatic test_stop;
    tx_ready = 1'b1;
    txq.delete();
    bus(32'h3_0008, 1'b1, 8'h55);
    bus(32'h3_000C, 1'b0, 8'h00);
    checks += 2;
    if (bus_if.mem_din !== 8'h00) begin
      $display("FAIL io_other: got %h expected 00", bus_if.mem_din);
      errors++;
    end
    if (halted !== 1'b0) begin
      $display("FAIL stop_pre: got %b expected 0", halted);
      errors++;
    end
    bus(32'h3_0004, 1'b1, 8'h99);
    checks += 2;
    if (prog_stop !== 1'b1) begin
      $display("FAIL stop_pulse: got %b expected 1", prog_stop);
      errors++;
    end
    if (halted !== 1'b1) begin
      $display("FAIL stop_halt: got %b expected 1", halted);
      errors++;
    end
    idle(1);
    checks += 2;
    if (prog_stop !== 1'b0) begin
      $display("FAIL stop_len: got %b expected 0", prog_stop);
      errors++;
    end
    if (halted !== 1'b1) begin
      $display("FAIL stop_sticky: got %b expected 1", halted);
      errors++;
    end
    idle(3);
    checks++;
    if (txq.size() !== 1) begin
      $display("FAIL stop_txlen: got %0d expected 1", txq.size());
      errors++;
    end else begin
      checks++;
      if (txq[0] !== 8'h00) begin
        $display("FAIL stop_tx: got %h expected 00", txq[0]);
        errors++;
      end
    end
  endtask

  task automatic test_rx;
    logic [7:0] exp [7];
`ifdef MEM_IO_RX_EN
    exp = '{8'h31, 8'h32, 8'h00,
            8'h50, 8'h51, 8'h52, 8'h53};
`else
    exp = '{default: 8'h00};
`endif
    rx_valid = 1'b1;
    rx_data = 8'h31;
    idle(1);
    rx_data = 8'h32;
    idle(1);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus(32'h3_0000, 1'b0, 8'h00);
      checks++;
      if (bus_if.mem_din !== exp[i]) begin
        $display("FAIL rx_rd%0d: got %h expected %h", i,
                 bus_if.mem_din, exp[i]);
        errors++;
      end
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h50 + 8'(i);
      idle(1);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(32'h3_0000, 1'b0, 8'h00);
      checks++;
      if (i < 4 && bus_if.mem_din !== exp[3 + i]) begin
        $display("FAIL rx_full%0d: got %h expected %h", i,
                 bus_if.mem_din, exp[3 + i]);
        errors++;
      end
      if (i == 4 && bus_if.mem_din !== 8'h00) begin
        $display("FAIL rx_drop: got %h expected 00",
                 bus_if.mem_din);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid;
    tx_ready = 1'b0;
    bus(32'h3_0000, 1'b1, 8'h61);
    bus(32'h3_0000, 1'b1, 8'h62);
    bus(32'h0_0040, 1'b1, 8'hA5);
    bus(32'h0_0040, 1'b0, 8'h00);
    checks += 2;
    if (bus_if.mem_din !== 8'hA5) begin
      $display("FAIL mid_pre: got %h expected a5", bus_if.mem_din);
      errors++;
    end
    if (tx_valid !== 1'b1) begin
      $display("FAIL mid_txv_pre: got %b expected 1", tx_valid);
      errors++;
    end
    rst = 1'b1;
    bus(32'h0_0040, 1'b0, 8'h00);
    rst = 1'b0;
    checks += 3;
    if (bus_if.mem_din !== 8'h00) begin
      $display("FAIL mid_din: got %h expected 00", bus_if.mem_din);
      errors++;
    end
    if (tx_valid !== 1'b0) begin
      $display("FAIL mid_txv: got %b expected 0", tx_valid);
      errors++;
    end
    if (halted !== 1'b0) begin
      $display("FAIL mid_halt: got %b expected 0", halted);
      errors++;
    end
    bus(32'h0_0040, 1'b0, 8'h00);
    checks++;
    if (bus_if.mem_din !== 8'hA5) begin
      $display("FAIL mid_ram: got %h expected a5", bus_if.mem_din);
      errors++;
    end
  endtask

  initial begin
    bus_if.mem_a = IDLE;
    bus_if.mem_wr = 1'b0;
    bus_if.mem_dout = 8'h00;
    @(negedge clk);
    test_reset();
    test_ram();
    test_tx();
    test_back_pressure();
    test_counter();
    test_stop();
    test_rx();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
